// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared field widths, FSM state encoding, tag-entry layout and
//               LRU helper functions for the 4-way data cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int TAG_W = 5;
    localparam int SET_W = 3;
    localparam int OFF_W = 4;
    localparam int WAYS  = 4;
    localparam int WORDS = 16;
    localparam int SETS  = 8;
    localparam int WAY_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_WB          = 3'd2,
        ST_REFILL_REQ  = 3'd3,
        ST_REFILL_WAIT = 3'd4,
        ST_RESP        = 3'd5
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // One 2-bit recency rank per way; rank 0 = most recently used
    typedef logic [WAYS-1:0][WAY_W-1:0] rank_vec_t;

    // Way holding the oldest rank
    function automatic logic [WAY_W-1:0] lru_victim(input rank_vec_t ranks);
        lru_victim = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (ranks[i] == WAY_W'(WAYS - 1)) begin
                lru_victim = WAY_W'(i);
            end
        end
    endfunction

    // Accessed way becomes rank 0; every way that was more recent ages by one
    function automatic rank_vec_t lru_update(input rank_vec_t ranks,
                                             input logic [WAY_W-1:0] way);
        lru_update = ranks;
        for (int i = 0; i < WAYS; i++) begin
            if (ranks[i] < ranks[way]) begin
                lru_update[i] = ranks[i] + WAY_W'(1);
            end
        end
        lru_update[way] = '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru
// Description : Per-set LRU rank storage; provides the LRU way of the selected
//               set and applies the rank update for an accessed way.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] set,
    input  logic             upd_en,
    input  logic [WAY_W-1:0] upd_way,
    output logic [WAY_W-1:0] victim_way
);

    rank_vec_t r_rank [SETS];

    // Rank storage: identity ranking on reset, LRU promotion on access
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_rank[s][w] <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            r_rank[set] <= lru_update(r_rank[set], upd_way);
        end
    end

    assign victim_way = lru_victim(r_rank[set]);

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Sequencing controller for a 4-way set-associative write-back,
//               write-allocate data cache (8 sets x 4 ways x 16 words).
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  read_hit_cnt,
    output logic [CNT_W-1:0]  read_miss_cnt,
    output logic [CNT_W-1:0]  write_hit_cnt,
    output logic [CNT_W-1:0]  write_miss_cnt
);

    localparam int DIDX_W = SET_W + WAY_W + OFF_W;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_hit;
    logic [WAY_W-1:0]    r_way;
    logic [OFF_W-1:0]    r_idx;
    tag_entry_t          r_tags [SETS][WAYS];
    logic [DATA_W-1:0]   r_data [SETS*WAYS*WORDS];
    logic                r_resp_valid;
    logic                r_resp_hit;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [CNT_W-1:0]    r_rh_cnt;
    logic [CNT_W-1:0]    r_rm_cnt;
    logic [CNT_W-1:0]    r_wh_cnt;
    logic [CNT_W-1:0]    r_wm_cnt;

    logic [TAG_W-1:0]    w_tag;
    logic [SET_W-1:0]    w_set;
    logic [OFF_W-1:0]    w_off;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_inv_found;
    logic [WAY_W-1:0]    w_inv_way;
    logic [WAY_W-1:0]    w_lru_way;
    logic [WAY_W-1:0]    w_fill_way;
    logic [DIDX_W-1:0]   w_idx_burst;
    logic [DIDX_W-1:0]   w_idx_off;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign w_tag       = r_addr[OFF_W+SET_W +: TAG_W];
    assign w_set       = r_addr[OFF_W +: SET_W];
    assign w_off       = r_addr[OFF_W-1:0];
    assign w_idx_burst = {w_set, r_way, r_idx};
    assign w_idx_off   = {w_set, r_way, w_off};
    assign w_fill_way  = w_inv_found ? w_inv_way : w_lru_way;

    cache_lru u_lru (
        .clk        (clk),
        .rst        (rst),
        .set        (w_set),
        .upd_en     (r_state == ST_RESP),
        .upd_way    (r_way),
        .victim_way (w_lru_way)
    );

    // Tag compare and lowest-index invalid way of the captured set
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (r_tags[w_set][i].valid && (r_tags[w_set][i].tag == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!r_tags[w_set][i].valid) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and memory-port drive
    always_comb begin
        w_next        = r_state;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_next = ST_RESP;
                end else if (r_tags[w_set][w_fill_way].valid && r_tags[w_set][w_fill_way].dirty) begin
                    w_next = ST_WB;
                end else begin
                    w_next = ST_REFILL_REQ;
                end
            end
            ST_WB: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = ADDR_W'({r_tags[w_set][r_way].tag, w_set, r_idx});
                mem_wdata     = r_data[w_idx_burst];
                if (mem_req_ready && (r_idx == OFF_W'(WORDS - 1))) begin
                    w_next = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = ADDR_W'({w_tag, w_set, r_idx});
                if (mem_req_ready) begin
                    w_next = ST_REFILL_WAIT;
                end
            end
            ST_REFILL_WAIT: begin
                if (mem_rvalid) begin
                    w_next = (r_idx == OFF_W'(WORDS - 1)) ? ST_RESP : ST_REFILL_REQ;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, hit/way bookkeeping and burst word index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
            r_way   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end
                end
                ST_LOOKUP: begin
                    r_hit <= w_hit;
                    r_way <= w_hit ? w_hit_way : w_fill_way;
                    r_idx <= '0;
                end
                ST_WB: begin
                    if (mem_req_ready) begin
                        r_idx <= r_idx + OFF_W'(1);
                    end
                end
                ST_REFILL_WAIT: begin
                    if (mem_rvalid) begin
                        r_idx <= r_idx + OFF_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag/valid/dirty state: installed on the last refill word, dirtied by writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_tags[s][w] <= '0;
                end
            end
        end else if ((r_state == ST_REFILL_WAIT) && mem_rvalid && (r_idx == OFF_W'(WORDS - 1))) begin
            r_tags[w_set][r_way] <= '{valid: 1'b1, dirty: 1'b0, tag: w_tag};
        end else if ((r_state == ST_RESP) && r_we) begin
            r_tags[w_set][r_way].dirty <= 1'b1;
        end
    end

    // Data array: refill words land before RESP, CPU writes land in RESP
    always_ff @(posedge clk) begin
        if ((r_state == ST_REFILL_WAIT) && mem_rvalid) begin
            r_data[w_idx_burst] <= mem_rdata;
        end else if ((r_state == ST_RESP) && r_we) begin
            r_data[w_idx_off] <= r_wdata;
        end
    end

    // Response registers and saturating hit/miss statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
            r_rh_cnt     <= '0;
            r_rm_cnt     <= '0;
            r_wh_cnt     <= '0;
            r_wm_cnt     <= '0;
        end else begin
            r_resp_valid <= (r_state == ST_RESP);
            r_resp_hit   <= (r_state == ST_RESP) && r_hit;
            if (r_state == ST_RESP) begin
                r_resp_rdata <= r_we ? r_wdata : r_data[w_idx_off];
                case ({r_we, r_hit})
                    2'b01:   r_rh_cnt <= sat_inc(r_rh_cnt);
                    2'b00:   r_rm_cnt <= sat_inc(r_rm_cnt);
                    2'b11:   r_wh_cnt <= sat_inc(r_wh_cnt);
                    default: r_wm_cnt <= sat_inc(r_wm_cnt);
                endcase
            end
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign resp_valid     = r_resp_valid;
    assign resp_hit       = r_resp_hit;
    assign resp_rdata     = r_resp_rdata;
    assign read_hit_cnt   = r_rh_cnt;
    assign read_miss_cnt  = r_rm_cnt;
    assign write_hit_cnt  = r_wh_cnt;
    assign write_miss_cnt = r_wm_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Scoreboard bench for cache_ctrl with a recency-list cache model
//               and a word-addressed memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_ctrl;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req_valid, mem_req_ready, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  read_hit_cnt, read_miss_cnt, write_hit_cnt, write_miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .read_hit_cnt(read_hit_cnt), .read_miss_cnt(read_miss_cnt),
        .write_hit_cnt(write_hit_cnt), .write_miss_cnt(write_miss_cnt)
    );

    typedef struct {
        bit          hit;
        logic [31:0] rdata;
        int          rh, rm, wh, wm;
    } resp_t;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] data;
    } memx_t;

    int          total = 0;
    int          bad   = 0;
    longint      cyc   = 0;
    longint      acc_cyc = 0;
    int          resp_seen = 0;
    int          wb_seen   = 0;
    bit          slow = 1'b0;

    logic [31:0] mem    [4096];
    logic [31:0] shadow [4096];
    bit          ldirty [256];
    int          lru_q  [8][$];
    int          cnt_rh, cnt_rm, cnt_wh, cnt_wm;
    resp_t       exp_q [$];
    memx_t       mem_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference model: per-set recency list of resident tags, a coherent
    // CPU-visible memory image, and per-line dirty flags.
    task automatic predict(input bit we, input logic [11:0] addr, input logic [31:0] wd);
        int    s, t, pos, v;
        resp_t e;
        s   = int'(addr[6:4]);
        t   = int'(addr[11:7]);
        pos = -1;
        for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == t) pos = i;
        e.hit = (pos >= 0);
        if (e.hit) begin
            lru_q[s].delete(pos);
        end else begin
            if (lru_q[s].size() == 4) begin
                v = lru_q[s].pop_back();
                if (ldirty[v*8+s]) begin
                    for (int i = 0; i < 16; i++) begin
                        logic [11:0] wa;
                        wa = 12'((v << 7) | (s << 4) | i);
                        mem_q.push_back('{1'b1, wa, shadow[wa]});
                    end
                end
                ldirty[v*8+s] = 1'b0;
            end
            for (int i = 0; i < 16; i++) begin
                mem_q.push_back('{1'b0, 12'((t << 7) | (s << 4) | i), 32'h0});
            end
            ldirty[t*8+s] = 1'b0;
        end
        lru_q[s].push_front(t);
        if (we) begin
            shadow[addr]  = wd;
            ldirty[t*8+s] = 1'b1;
        end
        if (we) begin if (e.hit) cnt_wh++; else cnt_wm++; end
        else    begin if (e.hit) cnt_rh++; else cnt_rm++; end
        e.rdata = shadow[addr];
        e.rh = cnt_rh; e.rm = cnt_rm; e.wh = cnt_wh; e.wm = cnt_wm;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) shadow[i] = mem[i];
        for (int i = 0; i < 256; i++)  ldirty[i] = 1'b0;
        for (int s = 0; s < 8; s++)    lru_q[s].delete();
        cnt_rh = 0; cnt_rm = 0; cnt_wh = 0; cnt_wm = 0;
        exp_q.delete();
        mem_q.delete();
    endtask

    task automatic issue_req(input bit we, input logic [11:0] addr, input logic [31:0] wd);
        int k;
        predict(we, addr, wd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        k = 0;
        forever begin
            @(negedge clk);
            if (req_ready || k > 200) break;
            k++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            finish_now();
        end
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int base);
        int k;
        k = 0;
        while (resp_seen == base && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        if (resp_seen == base) begin
            chk("resp_timeout", 64'd0, 64'd1);
            finish_now();
        end
    endtask

    task automatic do_req(input bit we, input logic [11:0] addr, input logic [31:0] wd);
        int base;
        base = resp_seen;
        issue_req(we, addr, wd);
        wait_resp(base);
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_req_ready"},  req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_hit"},   resp_hit, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_mem_valid"},  mem_req_valid, 0);
        chk({tag, "_mem_we"},     mem_we, 0);
        chk({tag, "_cnt_sum"},    read_hit_cnt | read_miss_cnt | write_hit_cnt | write_miss_cnt, 0);
    endtask

    // Memory responder: random (or deliberately slow) accept and read latency
    initial begin : mem_resp
        bit          rd_pend;
        logic [11:0] rd_addr;
        int          rd_dly, stall;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        rd_pend = 1'b0; rd_addr = '0; rd_dly = 0; stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_pend = 1'b0;
                stall   = 0;
            end else if (mem_req_valid) begin
                if (mem_req_ready) begin
                    stall = 0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else begin
                        rd_pend = 1'b1;
                        rd_addr = mem_addr;
                        rd_dly  = slow ? 3 : int'($urandom_range(0, 2));
                    end
                end else begin
                    stall++;
                end
            end
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[rd_addr];
                    rd_pend    = 1'b0;
                end else begin
                    rd_dly--;
                end
            end
            mem_req_ready = slow ? (stall >= 5) : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: memory traffic and responses popped from the scoreboard queues
    bit          pend = 1'b0, busy = 1'b0;
    logic [11:0] pend_addr;
    bit          pend_we;
    resp_t       e_mon;
    memx_t       m_mon;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            busy = 1'b0;
        end else begin
            if (pend) begin
                chk("mem_hold_valid", mem_req_valid, 1);
                if (mem_req_valid) begin
                    chk("mem_hold_addr", mem_addr, pend_addr);
                    chk("mem_hold_we", mem_we, pend_we);
                end
            end
            pend = 1'b0;
            if (mem_req_valid) begin
                if (mem_req_ready) begin
                    if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
                    else begin
                        m_mon = mem_q.pop_front();
                        chk("mem_we", mem_we, m_mon.we);
                        chk("mem_addr", mem_addr, m_mon.addr);
                        if (m_mon.we) chk("mem_wdata", mem_wdata, m_mon.data);
                    end
                    if (mem_we) wb_seen++;
                end else begin
                    pend      = 1'b1;
                    pend_addr = mem_addr;
                    pend_we   = mem_we;
                end
            end
            if (resp_valid) begin
                resp_seen++;
                if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    e_mon = exp_q.pop_front();
                    chk("resp_hit", resp_hit, e_mon.hit);
                    chk("resp_rdata", resp_rdata, e_mon.rdata);
                    chk("read_hit_cnt", read_hit_cnt, e_mon.rh);
                    chk("read_miss_cnt", read_miss_cnt, e_mon.rm);
                    chk("write_hit_cnt", write_hit_cnt, e_mon.wh);
                    chk("write_miss_cnt", write_miss_cnt, e_mon.wm);
                    chk("mem_traffic_left", mem_q.size(), 0);
                    if (e_mon.hit) chk("hit_latency", cyc - acc_cyc, 2);
                end
                busy = 1'b0;
            end else if (busy) begin
                chk("req_ready_busy", req_ready, 0);
            end
            if (req_valid && req_ready) busy = 1'b1;
        end
    end

    function automatic logic [11:0] mk(input int tag, input int set, input int off);
        return 12'((tag << 7) | (set << 4) | off);
    endfunction

    initial begin : stim
        int base;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_state("reset");

        // Cold miss, then write and read hits on the same line
        do_req(1'b0, 12'h022, 32'h0);
        do_req(1'b1, 12'h022, 32'h0000_00AB);
        do_req(1'b0, 12'h022, 32'h0);

        // Fill set 2, refresh tag 0, then tag 4 must replace tag 1
        for (int t = 1; t < 4; t++) do_req(1'b0, mk(t, 2, t), 32'h0);
        do_req(1'b0, mk(0, 2, 5), 32'h0);
        do_req(1'b0, mk(4, 2, 0), 32'h0);
        do_req(1'b0, mk(0, 2, 1), 32'h0);
        do_req(1'b0, mk(1, 2, 7), 32'h0);

        // Dirty tag 3, age it to LRU, then evict it
        do_req(1'b1, mk(3, 2, 5), 32'hDEAD_BEEF);
        do_req(1'b0, mk(0, 2, 0), 32'h0);
        do_req(1'b0, mk(1, 2, 0), 32'h0);
        do_req(1'b0, mk(4, 2, 0), 32'h0);
        do_req(1'b0, mk(6, 2, 9), 32'h0);
        do_req(1'b0, mk(3, 2, 5), 32'h0);

        // Slow memory on a dirty eviction
        do_req(1'b1, mk(7, 2, 3), 32'h1234_5678);
        for (int t = 0; t < 3; t++) do_req(1'b0, mk(t == 0 ? 3 : (t == 1 ? 6 : 0), 2, 2), 32'h0);
        slow = 1'b1;
        do_req(1'b0, mk(9, 2, 4), 32'h0);
        slow = 1'b0;

        // Reset while the eviction burst is on word 7
        for (int t = 0; t < 4; t++) do_req(1'b1, mk(t, 3, t), 32'hA5A5_0000 | 32'(t));
        base = wb_seen;
        issue_req(1'b0, mk(4, 3, 2), 32'h0);
        for (int k = 0; k < 2000 && wb_seen < base + 7; k++) begin
            @(posedge clk); #1;
        end
        chk("wb_reached_word7", wb_seen - base, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_state("midrst");
        model_reset();
        do_req(1'b0, mk(4, 3, 2), 32'h0);
        do_req(1'b0, mk(0, 3, 0), 32'h0);

        // Randomized traffic over a few sets with heavy tag reuse
        for (int n = 0; n < 120; n++) begin
            do_req(1'($urandom_range(0, 1)),
                   mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15))),
                   $urandom);
        end

        repeat (4) @(posedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("final_read_hits", read_hit_cnt, cnt_rh);
        chk("final_write_misses", write_miss_cnt, cnt_wm);
        finish_now();
    end

endmodule
`default_nettype wire
